// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Front-end hazard controller for the IF/ID register and the PC. Produces
//   the PC load enable, the IF/ID load/flush controls and the ID/EX bubble
//   so that the front end stalls on load-use hazards and instruction-memory
//   waits, and squashes wrong-path fetches after taken branches and jumps.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt      source operands of the instruction in ID
//   ex_mem_read, ex_rt            load in EX and its destination register
//   branch_taken, jump            control-flow redirect this cycle
//   mem_req, mem_ready            instruction fetch outstanding / data returned
//   pc_write, ifid_write          PC and IF/ID load enables
//   ifid_flush                    IF/ID loads a NOP instead of the fetched word
//   idex_bubble                   ID/EX receives zeroed control
//   state                         FSM state (debug)
//   stall_cnt, flush_cnt          saturating performance counters
//
// State table
//   state    | meaning
//   RUN   (0)| normal issue; hazards resolved in the same cycle
//   RSVD  (1)| unused encoding, behaves as RUN
//   FLUSH (2)| squashing wrong-path slots after a redirect
//   MEM_WAIT(3)| waiting for instruction memory, redirect may be pending
module pipeline_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RSVD     = 2'd1,
    S_FLUSH    = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  state_t          state_q;
  logic [FC_W-1:0] count_q;
  logic            pending_q;

  logic load_use;
  logic redirect;
  logic mem_stall;

  assign state     = state_q;
  assign redirect  = branch_taken | jump;
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Mealy outputs: a hazard must stall in the very cycle it is seen.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            ifid_flush  = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (!mem_ready) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        default: begin
          if (mem_stall || (!redirect && load_use)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (redirect) begin
            ifid_flush  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (!mem_stall) begin
            if (count_q <= FC_W'(1)) begin
              state_q <= S_RUN;
              count_q <= '0;
            end else begin
              count_q <= count_q - FC_W'(1);
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            pending_q <= 1'b0;
            if (pending_q || redirect) begin
              state_q <= S_FLUSH;
              count_q <= FC_W'(FLUSH_CYCLES);
            end else begin
              state_q <= S_RUN;
            end
          end else if (redirect) begin
            pending_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RUN;
          if (mem_stall) begin
            state_q   <= S_MEM_WAIT;
            pending_q <= redirect;
          end else if (redirect && (FLUSH_CYCLES > 1)) begin
            // The redirect cycle itself squashes one slot.
            state_q <= S_FLUSH;
            count_q <= FC_W'(FLUSH_CYCLES - 1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int FC    = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic             branch_taken = 1'b0, jump = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump(jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining squash slots, waiting-for-memory flag,
  // remembered redirect, and the two event tallies.
  int m_slots_left;
  bit m_waiting;
  bit m_pending;
  int m_stalls;
  int m_flushes;

  task automatic model_reset();
    m_slots_left = 0; m_waiting = 0; m_pending = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    if (!ex_mem_read || ex_rt == 0) return 0;
    return (ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt);
  endfunction

  task automatic set_in(input bit br, input bit jp, input bit rq, input bit rdy,
                        input bit mr, input int ert, input int rs, input int rt, input bit urt);
    branch_taken = br; jump = jp; mem_req = rq; mem_ready = rdy;
    ex_mem_read = mr; ex_rt = REG_W'(ert); id_rs = REG_W'(rs); id_rt = REG_W'(rt);
    id_uses_rt = urt;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    bit e_pc, e_if, e_fl, e_bub;
    int e_state;
    bit redir, mstall;
    redir  = branch_taken || jump;
    mstall = mem_req && !mem_ready;
    e_state = m_waiting ? 3 : (m_slots_left > 0 ? 2 : 0);
    {e_pc, e_if, e_fl, e_bub} = 4'b1100;
    if (m_waiting) begin
      if (!mem_ready) {e_pc, e_if, e_fl, e_bub} = 4'b0001;
    end else if (m_slots_left > 0) begin
      if (mstall) {e_pc, e_if, e_fl, e_bub} = 4'b0001;
      else        {e_pc, e_if, e_fl, e_bub} = 4'b1110;
    end else begin
      if (mstall)        {e_pc, e_if, e_fl, e_bub} = 4'b0001;
      else if (redir)    {e_pc, e_if, e_fl, e_bub} = 4'b1110;
      else if (hazard()) {e_pc, e_if, e_fl, e_bub} = 4'b0001;
    end
    #1;
    chk({tag, ".pc_write"},    int'(pc_write),    int'(e_pc));
    chk({tag, ".ifid_write"},  int'(ifid_write),  int'(e_if));
    chk({tag, ".ifid_flush"},  int'(ifid_flush),  int'(e_fl));
    chk({tag, ".idex_bubble"}, int'(idex_bubble), int'(e_bub));
    chk({tag, ".state"},       int'(state),       e_state);
    chk({tag, ".stall_cnt"},   int'(stall_cnt),   m_stalls);
    chk({tag, ".flush_cnt"},   int'(flush_cnt),   m_flushes);
    // advance the model to the next cycle
    if (m_waiting) begin
      if (mem_ready) begin
        if (m_pending || redir) m_slots_left = FC;
        m_waiting = 0; m_pending = 0;
      end else if (redir) m_pending = 1;
    end else if (m_slots_left > 0) begin
      if (!mstall) m_slots_left--;
    end else if (mstall) begin
      m_waiting = 1; m_pending = redir;
    end else if (redir) begin
      m_slots_left = FC - 1;
    end
    if (!e_pc && m_stalls < CMAX) m_stalls++;
    if (e_fl && m_flushes < CMAX) m_flushes++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst.pc_write",    int'(pc_write),    0);
    chk("rst.ifid_flush",  int'(ifid_flush),  1);
    chk("rst.idex_bubble", int'(idex_bubble), 1);
    do_reset();

    // load-use on rs
    set_in(0, 0, 0, 0, 1, 8, 8, 3, 0); cycle("lu_rs");
    set_in(0, 0, 0, 0, 0, 8, 8, 3, 0); cycle("lu_clear");
    chk("lu.stall_cnt", int'(stall_cnt), 1);

    // r0 never hazards; rt ignored when not used
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle("lu_r0");
    set_in(0, 0, 0, 0, 1, 9, 1, 9, 0); cycle("lu_rt_unused");
    set_in(0, 0, 0, 0, 1, 9, 1, 9, 1); cycle("lu_rt_used");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("lu_idle");

    // branch: two squashed slots, second-cycle branch ignored
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("br0");
    set_in(1, 0, 0, 0, 1, 4, 4, 0, 0); cycle("br1_ignored");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("br_after");
    chk("br.flush_cnt", int'(flush_cnt), 2);

    // memory wait with jump in second cycle
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("mw0");
    set_in(0, 1, 1, 0, 0, 0, 0, 0, 0); cycle("mw1_jump");
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("mw2");
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("mw_ready");
    chk("mw.stall_cnt", int'(stall_cnt), 3);
    chk("mw.state_flush", int'(state), 2);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle("mw_flush");

    // reset asserted in the middle of a flush
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle("rf_jump");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rf.in_flush", int'(state), 2);
    rst = 1'b1; #1;
    chk("rf.pc_write",   int'(pc_write),   0);
    chk("rf.ifid_flush", int'(ifid_flush), 1);
    chk("rf.state",      int'(state),      0);
    chk("rf.stall_cnt",  int'(stall_cnt),  0);
    chk("rf.flush_cnt",  int'(flush_cnt),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle("rf_after");

    // stall counter saturation
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (20) cycle("sat");
    chk("sat.stall_cnt", int'(stall_cnt), 15);
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("sat_release");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
